ripple_sampler: RTL and testbench

Brings the asynchronous outputs of the 3-bit ripple counter into the system `CLK` domain. It synchronizes each bit, waits for the value to stay stable, and publishes a clean registered count. It also flags wrap-around and any skipped count. The block sits directly downstream of the ripple counter and feeds display and control logic.

---
 rtl/ripple_pkg.sv | 26 ++
 rtl/bit_sync2.sv | 35 +++
 rtl/ripple_sampler.sv | 150 +++++++++++++++
 tb/tb_ripple_sampler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ripple_pkg.sv
// ripple_pkg
// Shared constants, types and helpers for the ripple-counter sampling logic.
// RIPPLE_WIDTH          : number of ripple-counter bits sampled
// STABLE_CYCLES_DEFAULT : identical synchronized samples needed to accept a value
// CNT_W                 : width of the stability counter (covers 1..15)
// ripple_count_t        : one sampled counter value
// next_count            : successor of a count, wrapping modulo 2^RIPPLE_WIDTH
package ripple_pkg;

  localparam int RIPPLE_WIDTH          = 3;
  localparam int STABLE_CYCLES_DEFAULT = 2;
  localparam int CNT_W                 = 4;

  typedef logic [RIPPLE_WIDTH-1:0] ripple_count_t;

  // SETTLE while the stability counter is below its target, LOCKED once reached.
  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } track_state_e;

  function automatic ripple_count_t next_count(input ripple_count_t value);
    return value + ripple_count_t'(1);
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// bit_sync2
// Two-flop synchronizer for a bus of independent asynchronous bits. Each bit is
// synchronized on its own; no cross-bit coherency is implied, the downstream
// stability filter takes care of that.
// Ports:
//   clk_i   : destination clock
//   rst_n_i : asynchronous active-low reset, both stages clear to 0
//   d_i     : asynchronous input bits
//   q_o     : synchronized bits (second flop stage)
module bit_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // First stage may go metastable; the second stage gives it a full cycle to resolve.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ripple_sampler.sv
// ripple_sampler
// Brings the asynchronous outputs of a ripple counter into the clk_i domain:
// synchronizes every bit, waits until the synchronized value has been steady for
// STABLE_CYCLES samples, and then publishes it as a clean registered count along
// with one-cycle pulses for change, wrap-around and skipped counts.
// Build option: define RIPPLE_SAMPLER_SKIP_CHECK_EN to build the skip detector and
// the sticky error flag. Without it skip_o and err_o are tied to 0 and clr_i is
// ignored; count_o, valid_o and wrap_o behave identically in both builds.
// Ports:
//   clk_i   : system clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   q_in_i  : raw ripple-counter bits, bit 0 = Q0 (LSB), asynchronous to clk_i
//   clr_i   : synchronous clear of err_o
//   count_o : last accepted count
//   valid_o : one-cycle pulse when count_o changes
//   wrap_o  : one-cycle pulse with valid_o on a max -> 0 transition
//   skip_o  : one-cycle pulse with valid_o when the new count is not old+1
//   err_o   : sticky flag set by skip_o
module ripple_sampler
  import ripple_pkg::*;
#(
  parameter int WIDTH         = RIPPLE_WIDTH,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] q_in_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             valid_o,
  output logic             wrap_o,
  output logic             skip_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] STEP     = WIDTH'(1);

  logic [WIDTH-1:0] syncVal;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             acceptEvt;
  logic             acceptNew;
  logic [WIDTH-1:0] expectedNext;
  track_state_e     trackState;

  bit_sync2 #(
    .W(WIDTH)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (q_in_i),
    .q_o    (syncVal)
  );

  assign trackState   = (cnt_q == STABLE_C) ? LOCKED : SETTLE;
  assign expectedNext = count_q + STEP;

  // Stability filter and publish logic. A new synchronized value restarts the
  // count at 1; with STABLE_CYCLES = 1 that restart is already the accept, so the
  // accepted value is always taken from syncVal, which equals the candidate in
  // the normal accept case.
  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    acceptEvt = 1'b0;
    acceptNew = 1'b0;

    if (syncVal != cand_q) begin
      cand_d = syncVal;
      cnt_d  = CNT_ONE;
      if (STABLE_C == CNT_ONE) begin
        acceptEvt = 1'b1;
      end
    end else if (trackState == SETTLE) begin
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_q == STABLE_C - CNT_ONE) begin
        acceptEvt = 1'b1;
      end
    end

    // Accepting the value already published (a glitch that came back) is silent.
    if (acceptEvt && (syncVal != count_q)) begin
      acceptNew = 1'b1;
      count_d   = syncVal;
      valid_d   = 1'b1;
      wrap_d    = (count_q == CNT_MAX) && (syncVal == '0);
    end
  end

  // Tracking and output registers; reset leaves the filter LOCKED on zero so an
  // idle counter produces no pulse after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cand_q  <= '0;
      cnt_q   <= STABLE_C;
      count_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;

`ifdef RIPPLE_SAMPLER_SKIP_CHECK_EN
  logic skip_q, skip_d;
  logic err_q, err_d;

  // A skip sets err in the same edge it is reported, and outranks a simultaneous clear.
  always_comb begin
    skip_d = acceptNew && (syncVal != expectedNext);
    err_d  = skip_d | (err_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      skip_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      skip_q <= skip_d;
      err_q  <= err_d;
    end
  end

  assign skip_o = skip_q;
  assign err_o  = err_q;
`else
  logic unused_skip_inputs;
  assign unused_skip_inputs = clr_i ^ acceptNew ^ (^expectedNext);
  assign skip_o = 1'b0;
  assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_sampler.sv
// tb_ripple_sampler
// Directed bench for ripple_sampler with the default configuration (3 bits,
// two stable samples). Inputs change and outputs are sampled on the falling
// edge, so a q_in change lands ahead of the next rising edge ("edge 1") and the
// accepted count is visible at the falling edge after edge 4.
// Skip/error expectations follow RIPPLE_SAMPLER_SKIP_CHECK_EN.
module tb_ripple_sampler;

`ifdef RIPPLE_SAMPLER_SKIP_CHECK_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  logic       clk;
  logic       rstN;
  logic [2:0] qIn;
  logic       clr;
  logic [2:0] count;
  logic       valid;
  logic       wrap;
  logic       skip;
  logic       err;

  int checks = 0;
  int errors = 0;
  int validSeen;
  int wrapSeen;
  int skipSeen;
  int validTotal;
  int wrapTotal;
  int skipTotal;

  ripple_sampler #(
    .WIDTH        (3),
    .STABLE_CYCLES(2)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rstN),
    .q_in_i (qIn),
    .clr_i  (clr),
    .count_o(count),
    .valid_o(valid),
    .wrap_o (wrap),
    .skip_o (skip),
    .err_o  (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance n falling edges while tallying every output pulse seen.
  task automatic applyStimulus(input int n);
    validSeen = 0;
    wrapSeen  = 0;
    skipSeen  = 0;
    repeat (n) begin
      @(negedge clk);
      validSeen += int'(valid);
      wrapSeen  += int'(wrap);
      skipSeen  += int'(skip);
    end
  endtask

  initial begin
    rstN = 1'b0;
    qIn  = 3'd0;
    clr  = 1'b0;

    // Clean reset
    applyStimulus(2);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    rstN = 1'b1;
    applyStimulus(10);
    checkOutput("idle_valid_pulses", 32'(validSeen), 32'd0);
    checkOutput("idle_wrap_pulses", 32'(wrapSeen), 32'd0);
    checkOutput("idle_skip_pulses", 32'(skipSeen), 32'd0);
    checkOutput("idle_count", 32'(count), 32'd0);
    checkOutput("idle_err", 32'(err), 32'd0);

    // Normal step 0 -> 1: nothing before edge 4, a single pulse at edge 4
    qIn = 3'd1;
    applyStimulus(3);
    checkOutput("step_early_valid", 32'(validSeen), 32'd0);
    checkOutput("step_early_count", 32'(count), 32'd0);
    applyStimulus(1);
    checkOutput("step_valid", 32'(valid), 32'd1);
    checkOutput("step_count", 32'(count), 32'd1);
    checkOutput("step_wrap", 32'(wrap), 32'd0);
    checkOutput("step_skip", 32'(skip), 32'd0);
    applyStimulus(1);
    checkOutput("step_pulse_width", 32'(valid), 32'd0);

    // Full sequence 1 -> 2 .. 7 -> 0 -> 1, eight clean steps, one wrap
    validTotal = 0;
    wrapTotal  = 0;
    skipTotal  = 0;
    for (int i = 2; i <= 9; i++) begin
      qIn = 3'(i);
      applyStimulus(8);
      validTotal += validSeen;
      wrapTotal  += wrapSeen;
      skipTotal  += skipSeen;
    end
    checkOutput("seq_valid_pulses", 32'(validTotal), 32'd8);
    checkOutput("seq_wrap_pulses", 32'(wrapTotal), 32'd1);
    checkOutput("seq_skip_pulses", 32'(skipTotal), 32'd0);
    checkOutput("seq_count", 32'(count), 32'd1);
    checkOutput("seq_err", 32'(err), 32'd0);

    // Skip detection from 2 -> 5
    qIn = 3'd2;
    applyStimulus(8);
    checkOutput("pre_skip_count", 32'(count), 32'd2);
    qIn = 3'd5;
    applyStimulus(4);
    checkOutput("skip_valid", 32'(valid), 32'd1);
    checkOutput("skip_count", 32'(count), 32'd5);
    checkOutput("skip_pulse", 32'(skip), 32'(SKIP_EN));
    checkOutput("skip_err", 32'(err), 32'(SKIP_EN));
    checkOutput("skip_wrap", 32'(wrap), 32'd0);
    applyStimulus(3);
    checkOutput("err_sticky", 32'(err), 32'(SKIP_EN));
    clr = 1'b1;
    applyStimulus(1);
    clr = 1'b0;
    checkOutput("clr_err", 32'(err), 32'd0);

    // Second skip 5 -> 3 with clr high on the accepting edge: set wins
    qIn = 3'd3;
    applyStimulus(3);
    clr = 1'b1;
    applyStimulus(1);
    clr = 1'b0;
    checkOutput("skip2_count", 32'(count), 32'd3);
    checkOutput("skip2_pulse", 32'(skip), 32'(SKIP_EN));
    checkOutput("skip2_err_set_wins", 32'(err), 32'(SKIP_EN));
    applyStimulus(4);

    // Glitch to 7 for a single cycle, then back to 3
    qIn = 3'd7;
    applyStimulus(1);
    qIn = 3'd3;
    applyStimulus(10);
    checkOutput("glitch_valid_pulses", 32'(validSeen), 32'd0);
    checkOutput("glitch_count", 32'(count), 32'd3);

    // Async reset while settling 4 -> 5
    qIn = 3'd4;
    applyStimulus(8);
    checkOutput("pre_reset_count", 32'(count), 32'd4);
    qIn = 3'd5;
    applyStimulus(2);
    @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_valid", 32'(valid), 32'd0);
    checkOutput("async_rst_err", 32'(err), 32'd0);
    applyStimulus(2);
    rstN = 1'b1;
    applyStimulus(3);
    checkOutput("post_rst_early_count", 32'(count), 32'd0);
    checkOutput("post_rst_early_valid", 32'(validSeen), 32'd0);
    applyStimulus(1);
    checkOutput("post_rst_count", 32'(count), 32'd5);
    checkOutput("post_rst_valid", 32'(valid), 32'd1);
    checkOutput("post_rst_skip", 32'(skip), 32'(SKIP_EN));
    checkOutput("post_rst_err", 32'(err), 32'(SKIP_EN));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
